fb_fill_engine: RTL
===================

Name: fb_fill_engine

Overview:
- Hardware rectangle-fill engine and write-port arbiter for the 8-bit-per-pixel graphics framebuffer. The framebuffer is the dual-port RAM bank selected by hid_addr[19].
- Sits on the clk_i side between the CPU hid bus and the framebuffer B-port.
- Sequences 64-bit byte-masked writes that fill an axis-aligned rectangle with one palette index.
- CPU accesses always take the port; engine writes use idle cycles.

Parameters:
- STRIDE_W, 12, width of line stride, x, y, width and height fields (bytes/pixels)
- BASE_W, 19, width of framebuffer byte base address (fills hid_addr[18:0])

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  synchronous, active-high reset
- cpu_en  in  1  CPU framebuffer access (already qualified with hid_addr[19])
- cpu_addr  in  20  CPU byte address
- cpu_we  in  8  CPU byte write enables
- cpu_wrdata  in  64  CPU write data
- fb_en  out  1  framebuffer port enable
- fb_addr  out  20  framebuffer byte address, [19]=1, [2:0]=0 for engine writes
- fb_we  out  8  framebuffer byte enables
- fb_wrdata  out  64  framebuffer write data
- cfg_base  in  BASE_W  rectangle surface base byte address
- cfg_stride  in  STRIDE_W  bytes per line
- cfg_x, cfg_y  in  STRIDE_W  rectangle origin
- cfg_w, cfg_h  in  STRIDE_W  rectangle size in pixels
- cfg_colour  in  8  palette index to fill
- start  in  1  one-cycle start pulse
- abort  in  1  one-cycle abort pulse
- busy  out  1  engine not IDLE
- done  out  1  one-cycle completion pulse
- eng_stall  out  1  engine had a write pending but lost to CPU this cycle

Behaviour:
- Reset: state IDLE; busy=0, done=0, eng_stall=0; engine write strobe 0. fb_* then follow cpu_* combinationally.
- Arbitration (combinational):
  - cpu_en=1: fb_* = cpu_* verbatim (zero latency).
  - Else, if the engine issues: fb_en=1, fb_addr={1'b1,cur[18:3],3'b000}, fb_we=mask, fb_wrdata={8{colour}}.
  - Else fb_en=0 and fb_we=0.
- FSM states: IDLE, SETUP, ROW, WRITE, DONE.
- IDLE:
  - start=1: latch all cfg_* and go to SETUP.
  - start while busy is ignored.
- SETUP (1 cycle):
  - row_addr = base + y*stride + x, computed mod 2^BASE_W; rows_left = h.
  - If w==0 or h==0, go to DONE; else go to ROW.
- ROW (1 cycle): cur = row_addr; rem = w. Go to WRITE.
- WRITE:
  - lo = cur[2:0]; n = min(8-lo, rem); mask = ((1<<n)-1)<<lo.
  - Issue only when cpu_en=0. When cpu_en=1, hold all state and assert eng_stall.
  - On issue: cur += n; rem -= n.
  - If rem==n (last word of the row): rows_left -= 1. If rows_left==1, go to DONE; else row_addr += stride and go to ROW.
- DONE: done=1 for exactly one cycle, then IDLE.
- busy=1 in SETUP, ROW, WRITE and DONE.
- abort in any non-IDLE state:
  - Next state is IDLE, no done pulse.
  - Abort has priority: no engine write is issued in the abort cycle.
  - Writes already issued are not undone.
- start and abort in the same cycle from IDLE: abort wins, stay IDLE.
- Address arithmetic wraps modulo 2^19; fb_addr[19] is forced to 1 for engine writes.
- Latency: with no CPU contention, the first write is in cycle start+3. Each 64-bit word costs 1 cycle plus 1 ROW cycle per line. done comes 1 cycle after the last write.
- rst_i mid-operation: immediate return to IDLE, no done, no further writes.

Test Plan:
- Basic fill: base=0x100, stride=64, x=3, y=2, w=10, h=2, colour=0xA5, cpu idle -> exactly four writes, each with fb_wrdata=0xA5A5A5A5A5A5A5A5:
  - fb_addr 0x80180, fb_we 0xF8
  - fb_addr 0x80188, fb_we 0x1F
  - fb_addr 0x801C0, fb_we 0xF8
  - fb_addr 0x801C8, fb_we 0x1F
  - First write at start+3; done one cycle after the 4th write; busy low the cycle after done.
- Aligned, within one word: x=0, w=8, h=1 -> single write, fb_we=0xFF. With x=2, w=3 -> single write, fb_we=0x1C.
- CPU contention: hold cpu_en=1 (cpu_addr=0x80000, cpu_we=0x01) for 5 cycles during WRITE -> fb_* equals cpu_* for those 5 cycles; eng_stall=1; engine sequence resumes with no lost or duplicated words.
- Degenerate sizes: w=0, h=5 -> no fb_en from engine; done at start+2.
- Abort: abort during the 2nd write of the basic fill -> that write is suppressed; IDLE the next cycle; no done. A new start is then accepted.
- Wrap and ignored start:
  - base=0x7FFF8, x=4, w=8, h=1 -> writes at 0xFFFF8 (fb_we 0xF0) then 0x80000 (fb_we 0x0F).
  - A start pulse while busy does not change the latched parameters.

Source files
------------

// File: rtl/fb_fill_engine.sv
// fb_fill_engine: rectangle fill engine and framebuffer write-port arbiter.
// CPU accesses own the port; engine byte-masked fills use idle cycles.
module fb_fill_engine #(
    parameter int STRIDE_W = 12,
    parameter int BASE_W   = 19
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                cpu_en,
    input  logic [19:0]         cpu_addr,
    input  logic [7:0]          cpu_we,
    input  logic [63:0]         cpu_wrdata,
    output logic                fb_en,
    output logic [19:0]         fb_addr,
    output logic [7:0]          fb_we,
    output logic [63:0]         fb_wrdata,
    input  logic [BASE_W-1:0]   cfg_base,
    input  logic [STRIDE_W-1:0] cfg_stride,
    input  logic [STRIDE_W-1:0] cfg_x,
    input  logic [STRIDE_W-1:0] cfg_y,
    input  logic [STRIDE_W-1:0] cfg_w,
    input  logic [STRIDE_W-1:0] cfg_h,
    input  logic [7:0]          cfg_colour,
    input  logic                start,
    input  logic                abort,
    output logic                busy,
    output logic                done,
    output logic                eng_stall
);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        ROW,
        WRITE,
        DONE
    } state_t;

    state_t state, state_n;

    logic [BASE_W-1:0]     base_q;
    logic [STRIDE_W-1:0]   stride_q;
    logic [STRIDE_W-1:0]   x_q;
    logic [STRIDE_W-1:0]   y_q;
    logic [STRIDE_W-1:0]   w_q;
    logic [STRIDE_W-1:0]   h_q;
    logic [7:0]            colour_q;

    logic [BASE_W-1:0]     row_addr;
    logic [BASE_W-1:0]     cur;
    logic [STRIDE_W-1:0]   rem;
    logic [STRIDE_W-1:0]   rows_left;

    logic [2*STRIDE_W-1:0] prod;
    logic [BASE_W-1:0]     row_calc;
    logic [2:0]            lo;
    logic [3:0]            room;
    logic [3:0]            n;
    logic [15:0]           mask_w;
    logic [7:0]            mask;
    logic                  last;
    logic                  eng_issue;

    // Per-word geometry: bytes left in this 8-byte word vs. bytes left in row
    always_comb begin
        prod     = y_q * stride_q;
        row_calc = base_q + prod[BASE_W-1:0] + BASE_W'(x_q);
        lo       = cur[2:0];
        room     = 4'd8 - {1'b0, lo};
        last     = (rem <= STRIDE_W'(room));
        n        = last ? rem[3:0] : room;
        mask_w   = ((16'd1 << n) - 16'd1) << lo;
        mask     = mask_w[7:0];
    end

    // Engine write happens only on a free port and never in abort/reset cycles
    always_comb begin
        eng_issue = (state == WRITE) && !cpu_en && !abort && !rst_i;
        eng_stall = (state == WRITE) && cpu_en;
        busy      = (state != IDLE);
        done      = (state == DONE) && !abort;
    end

    // Port arbiter: CPU passes through untouched, engine fills otherwise
    always_comb begin
        fb_en     = 1'b0;
        fb_addr   = cpu_addr;
        fb_we     = 8'h00;
        fb_wrdata = cpu_wrdata;
        if (cpu_en) begin
            fb_en     = 1'b1;
            fb_we     = cpu_we;
        end else if (eng_issue) begin
            fb_en     = 1'b1;
            fb_addr   = {1'b1, cur[BASE_W-1:3], 3'b000};
            fb_we     = mask;
            fb_wrdata = {8{colour_q}};
        end
    end

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state logic; abort overrides everything
    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_n = SETUP;
                end
            end
            SETUP: begin
                if (w_q == '0 || h_q == '0) begin
                    state_n = DONE;
                end else begin
                    state_n = ROW;
                end
            end
            ROW: begin
                state_n = WRITE;
            end
            WRITE: begin
                if (eng_issue && last) begin
                    if (rows_left == STRIDE_W'(1)) begin
                        state_n = DONE;
                    end else begin
                        state_n = ROW;
                    end
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
        if (abort) begin
            state_n = IDLE;
        end
    end

    // Datapath: latch config, walk rows and words
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            base_q    <= '0;
            stride_q  <= '0;
            x_q       <= '0;
            y_q       <= '0;
            w_q       <= '0;
            h_q       <= '0;
            colour_q  <= '0;
            row_addr  <= '0;
            cur       <= '0;
            rem       <= '0;
            rows_left <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start && !abort) begin
                        base_q   <= cfg_base;
                        stride_q <= cfg_stride;
                        x_q      <= cfg_x;
                        y_q      <= cfg_y;
                        w_q      <= cfg_w;
                        h_q      <= cfg_h;
                        colour_q <= cfg_colour;
                    end
                end
                SETUP: begin
                    row_addr  <= row_calc;
                    rows_left <= h_q;
                end
                ROW: begin
                    cur <= row_addr;
                    rem <= w_q;
                end
                WRITE: begin
                    if (eng_issue) begin
                        cur <= cur + BASE_W'(n);
                        rem <= rem - STRIDE_W'(n);
                        if (last) begin
                            rows_left <= rows_left - STRIDE_W'(1);
                            if (rows_left != STRIDE_W'(1)) begin
                                row_addr <= row_addr + BASE_W'(stride_q);
                            end
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
